bcd_ndigit_conv: RTL and testbench
==================================

# bcd_ndigit_conv

Parametrised sequential binary-to-BCD converter driving the multi-digit display path. Converts a WIDTH-bit unsigned binary value into DIGITS packed BCD digits by repeated bit-serial division by ten. Adds leading-zero blanking, overflow detection and a done pulse. Output digits are held stable between conversions, so the display scanner can read them at any time.

## Interface
- WIDTH, 14, binary input width; must be ≥ 4.
- DIGITS, 4, number of BCD digits produced; must be ≥ 1.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only while ready=1.
- value  input  WIDTH  unsigned binary operand; captured on the accepting edge.
- ready  output  1  idle and able to accept start.
- done  output  1  one-cycle pulse when new results are presented.
- digits  output  4*DIGITS  packed BCD; digits[3:0] is the least significant digit.
- blank  output  DIGITS  bit k=1: digit k is a leading zero. Bit 0 is never set.
- overflow  output  1  the last operand was ≥ 10^DIGITS.

## Operation
- States: IDLE, DIV, STORE, FIN.
- IDLE: ready=1.
  - start=1 → capture value into the dividend register.
  - Clear the remainder (4 bits), the bit counter and the digit index k.
  - Go to DIV.
- DIV: processes one dividend bit per cycle, MSB first.
  - t = {rem, dividend MSB} (5 bits).
  - If t ≥ 10: rem = t−10 and quotient bit = 1. Otherwise rem = t[3:0] and quotient bit = 0.
  - The quotient bit shifts into the dividend LSB.
  - After WIDTH cycles, go to STORE.
- STORE:
  - Working digit k = rem. Clear rem and the bit counter.
  - Dividend now holds the quotient and becomes the next dividend.
  - If k = DIGITS−1, go to FIN. Otherwise k = k+1 and go to DIV.
- FIN:
  - overflow = (remaining quotient ≠ 0).
  - Copy the working digits to the digits output and compute blank.
  - done=1 for this cycle; go to IDLE.
- blank[k] = 1 when k ≠ 0 and digits k..DIGITS−1 are all zero.
- On overflow, digits = value mod 10^DIGITS. blank follows that digit pattern.
- Counter widths use $clog2(WIDTH+1) and $clog2(DIGITS+1). The remainder never exceeds 9.

## Timing
- Reset values:
  - ready=1, done=0, overflow=0, digits=0.
  - blank = all ones except bit 0.
  - State IDLE, all working registers 0.
- Latency: edge E0 accepts start. done is high in the cycle after edge E0 + DIGITS·(WIDTH+1) + 1. With defaults that is 61 edges.
- ready falls after E0 and rises on the same edge that raises done. A new start may be accepted in the done cycle.
- digits, blank and overflow change only on the FIN edge. They hold their previous values throughout a conversion.
- start while ready=0 is ignored; no queuing. value changes after E0 have no effect.
- rst and start in the same cycle: reset wins; no conversion begins.
- rst mid-conversion aborts the conversion. All outputs return to reset values on that edge; no done pulse.
- start held high continuously gives back-to-back conversions, each re-sampling value in its done cycle.

## Test plan
- Defaults, value=36, one-cycle start:
  - digits=16'h0036, blank=4'b1100, overflow=0.
  - done exactly 61 edges after E0, one cycle wide; ready low in between.
- value=0 → digits=16'h0000, blank=4'b1110, overflow=0. value=9999 → digits=16'h9999, blank=4'b0000, overflow=0.
- value=16383 → digits=16'h6383, overflow=1, blank=4'b0000. Then value=10000 → digits=16'h0000, overflow=1, blank=4'b1110.
- Convert 1234. Pulse start again at edge E0+20 with value=42:
  - The second start is ignored; the result is 16'h1234.
  - digits keeps 16'h1234 until the next FIN.
- Start value=777, assert rst at edge E0+30:
  - All outputs go to reset values; ready=1; no done pulse.
  - A subsequent conversion of 5 gives digits=16'h0005, blank=4'b1110.
- WIDTH=17, DIGITS=5:
  - 99999 → 20'h99999, overflow=0, done at E0+91.
  - 131071 → 20'h31071, overflow=1.

Source files
------------

// File: rtl/bcd_ndigit_conv.sv
// bcd_ndigit_conv: sequential binary-to-BCD converter for the multi-digit display path.
// The operand is divided by ten bit-serially, MSB first. Each pass of WIDTH cycles yields
// one remainder, which becomes the next BCD digit. The quotient is fed back as the next
// dividend. Results are presented all at once, so they stay stable for the display scanner.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    conversion request, honoured only while ready=1
//   value    WIDTH-bit unsigned operand, captured on the accepting edge
//   ready    idle, can accept start
//   done     one-cycle pulse when new digits/blank/overflow are presented
//   digits   packed BCD, digits[3:0] is the least significant digit
//   blank    per-digit leading-zero flag; bit 0 is never set
//   overflow last operand did not fit in DIGITS decimal digits
module bcd_ndigit_conv #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned KW = $clog2(DIGITS + 1);

    localparam logic [CW-1:0]     CntLast  = CW'(WIDTH - 1);
    localparam logic [KW-1:0]     KLast    = KW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] BlankRst = ~(DIGITS'(1));

    typedef enum logic [1:0] {StIdle, StDiv, StStore, StFin} state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      div_q, div_d;
    logic [3:0]            rem_q, rem_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [KW-1:0]         k_q, k_d;
    logic [4*DIGITS-1:0]   work_q, work_d;
    logic [4*DIGITS-1:0]   digits_q, digits_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    logic [4:0]            t;
    logic                  qbit;
    logic [DIGITS-1:0]     blank_nx;
    logic                  allz;

    // Leading-zero flags from the freshly converted digits, scanning from the top digit down.
    always_comb begin
        blank_nx = '0;
        allz     = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (work_q[4*i +: 4] != 4'd0) begin
                allz = 1'b0;
            end
            blank_nx[i] = (i != 0) && allz;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        work_d   = work_q;
        digits_d = digits_q;
        blank_d  = blank_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        t        = {rem_q, div_q[WIDTH-1]};
        qbit     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    div_d   = value;
                    rem_d   = '0;
                    cnt_d   = '0;
                    k_d     = '0;
                    state_d = StDiv;
                end
            end
            StDiv: begin
                // Restoring division step; t never exceeds 19 since rem stays at most 9.
                if (t >= 5'd10) begin
                    rem_d = 4'(t - 5'd10);
                    qbit  = 1'b1;
                end else begin
                    rem_d = t[3:0];
                end
                div_d = {div_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StStore;
                end
            end
            StStore: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (KW'(i) == k_q) begin
                        work_d[4*i +: 4] = rem_q;
                    end
                end
                rem_d = '0;
                cnt_d = '0;
                if (k_q == KLast) begin
                    state_d = StFin;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = StDiv;
                end
            end
            StFin: begin
                // Any quotient left after DIGITS passes means the operand did not fit.
                ovf_d    = |div_q;
                digits_d = work_q;
                blank_d  = blank_nx;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            div_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            work_q   <= '0;
            digits_q <= '0;
            blank_q  <= BlankRst;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            work_q   <= work_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign ready    = (state_q == StIdle);
    assign done     = done_q;
    assign digits   = digits_q;
    assign blank    = blank_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_ndigit_conv.sv
// Directed bench for bcd_ndigit_conv: default instance (14 bits, 4 digits) plus a
// 17-bit, 5-digit instance. Expected results are hand-computed decimal conversions.
module tb_bcd_ndigit_conv;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_a;
    logic [13:0] value_a;
    logic        ready_a, done_a, ovf_a;
    logic [15:0] digits_a;
    logic [3:0]  blank_a;

    logic        start_b;
    logic [16:0] value_b;
    logic        ready_b, done_b, ovf_b;
    logic [19:0] digits_b;
    logic [4:0]  blank_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_ndigit_conv #(.WIDTH(14), .DIGITS(4)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .value    (value_a),
        .ready    (ready_a),
        .done     (done_a),
        .digits   (digits_a),
        .blank    (blank_a),
        .overflow (ovf_a)
    );

    bcd_ndigit_conv #(.WIDTH(17), .DIGITS(5)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .value    (value_b),
        .ready    (ready_b),
        .done     (done_b),
        .digits   (digits_b),
        .blank    (blank_b),
        .overflow (ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge after the accepting edge. Returns edges counted until done
    // is seen, whether ready stayed low and digits stayed put meanwhile. Optionally
    // pulses start (value pv) so that it is sampled on edge pulse_at.
    task automatic wait_done_a(input int pulse_at, input logic [13:0] pv, output int n,
                               output bit rdy_ok, output bit hold_ok);
        logic [15:0] d0;
        d0      = digits_a;
        n       = 0;
        rdy_ok  = 1'b1;
        hold_ok = 1'b1;
        while (n < 200 && !done_a) begin
            if (ready_a) rdy_ok = 1'b0;
            if (digits_a !== d0) hold_ok = 1'b0;
            if (n == pulse_at - 1) begin
                start_a = 1'b1;
                value_a = pv;
            end else if (n == pulse_at) begin
                start_a = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic conv_a(input logic [13:0] v, input logic [15:0] ed, input logic [3:0] eb,
                          input logic eo, input int pulse_at, input string tag);
        int n;
        bit r, h;
        @(negedge clk);
        check({tag, " ready before"}, 32'(ready_a), 32'd1);
        start_a = 1'b1;
        value_a = v;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        value_a = ~v;
        wait_done_a(pulse_at, 14'd42, n, r, h);
        check({tag, " latency"}, 32'(n), 32'd61);
        check({tag, " ready low"}, 32'(r), 32'd1);
        check({tag, " hold"}, 32'(h), 32'd1);
        check({tag, " digits"}, 32'(digits_a), 32'(ed));
        check({tag, " blank"}, 32'(blank_a), 32'(eb));
        check({tag, " overflow"}, 32'(ovf_a), 32'(eo));
        check({tag, " ready at done"}, 32'(ready_a), 32'd1);
        @(negedge clk);
        check({tag, " done width"}, 32'(done_a), 32'd0);
    endtask

    task automatic conv_b(input logic [16:0] v, input logic [19:0] ed, input logic [4:0] eb,
                          input logic eo, input string tag);
        int n;
        @(negedge clk);
        start_b = 1'b1;
        value_b = v;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (n < 300 && !done_b) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(n), 32'd91);
        check({tag, " digits"}, 32'(digits_b), 32'(ed));
        check({tag, " blank"}, 32'(blank_b), 32'(eb));
        check({tag, " overflow"}, 32'(ovf_b), 32'(eo));
    endtask

    initial begin
        int  n;
        bit  r, h;
        bit  saw_done;

        rst     = 1'b1;
        start_a = 1'b0;
        value_a = '0;
        start_b = 1'b0;
        value_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", 32'(ready_a), 32'd1);
        check("reset done", 32'(done_a), 32'd0);
        check("reset digits", 32'(digits_a), 32'h0);
        check("reset blank", 32'(blank_a), 32'b1110);
        check("reset overflow", 32'(ovf_a), 32'd0);
        check("reset blank b", 32'(blank_b), 32'b11110);
        rst = 1'b0;

        conv_a(14'd36,    16'h0036, 4'b1100, 1'b0, -5, "v36");
        conv_a(14'd0,     16'h0000, 4'b1110, 1'b0, -5, "v0");
        conv_a(14'd9999,  16'h9999, 4'b0000, 1'b0, -5, "v9999");
        conv_a(14'd16383, 16'h6383, 4'b0000, 1'b1, -5, "v16383");
        conv_a(14'd10000, 16'h0000, 4'b1110, 1'b1, -5, "v10000");
        // Second start at E0+20 must be ignored.
        conv_a(14'd1234,  16'h1234, 4'b0000, 1'b0, 20, "v1234 ignored start");
        // Hold check in this run confirms 1234 persists until its FIN.
        conv_a(14'd36,    16'h0036, 4'b1100, 1'b0, -5, "v36 after 1234");

        // Reset mid-conversion at E0+30.
        @(negedge clk);
        start_a = 1'b1;
        value_a = 14'd777;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort ready", 32'(ready_a), 32'd1);
        check("abort done", 32'(done_a), 32'd0);
        check("abort digits", 32'(digits_a), 32'h0);
        check("abort blank", 32'(blank_a), 32'b1110);
        check("abort overflow", 32'(ovf_a), 32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done_a) saw_done = 1'b1;
        end
        check("abort no done", 32'(saw_done), 32'd0);
        conv_a(14'd5, 16'h0005, 4'b1110, 1'b0, -5, "v5 after abort");

        // Reset and start together: reset wins.
        @(negedge clk);
        rst     = 1'b1;
        start_a = 1'b1;
        value_a = 14'd100;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        start_a = 1'b0;
        check("rst+start ready", 32'(ready_a), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("rst+start still idle", 32'(ready_a), 32'd1);

        // start held high: back-to-back conversions, value re-sampled in the done cycle.
        @(negedge clk);
        start_a = 1'b1;
        value_a = 14'd55;
        @(posedge clk);
        @(negedge clk);
        wait_done_a(-5, 14'd0, n, r, h);
        check("b2b first latency", 32'(n), 32'd61);
        check("b2b first digits", 32'(digits_a), 32'h0055);
        value_a = 14'd7;
        @(posedge clk);
        @(negedge clk);
        value_a = 14'd3;
        check("b2b restarted", 32'(ready_a), 32'd0);
        wait_done_a(-5, 14'd0, n, r, h);
        start_a = 1'b0;
        check("b2b second latency", 32'(n), 32'd61);
        check("b2b second digits", 32'(digits_a), 32'h0007);
        check("b2b second blank", 32'(blank_a), 32'b1110);
        @(negedge clk);
        check("b2b stops", 32'(ready_a), 32'd1);

        conv_b(17'd99999,  20'h99999, 5'b00000, 1'b0, "w17 99999");
        conv_b(17'd131071, 20'h31071, 5'b00000, 1'b1, "w17 131071");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
